// File: rtl/ft2232_fifo_ctrl.sv
// FT2232 asynchronous FIFO-mode controller: arbitrates reads, writes and
// send-immediate requests onto the shared bus with registered, glitch-free strobes.
module ft2232_fifo_ctrl #(
    parameter int DATA    = 8,
    parameter int RD_CYC  = 4,
    parameter int WR_CYC  = 4,
    parameter int REC_CYC = 3
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire [DATA-1:0]  DBUS,
    input  logic            RXF,
    input  logic            TXE,
    output logic            RD,
    output logic            WR,
    output logic            SIWU,
    output logic [DATA-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    input  logic [DATA-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic            flush,
    output logic            busy
);

    // state      | meaning
    // IDLE       | strobes high, arbitrate flush / read / write
    // RD_PULSE   | RD low, bus sampled on the last low cycle
    // WR_SETUP   | byte latched and driven, tx_ready pulse, WR still high
    // WR_PULSE   | WR low with bus driven
    // WR_HOLD    | WR high, bus still driven for one cycle
    // SIWU_PULSE | SIWU low
    // RECOVER    | all strobes high so FT2232 flags settle through the synchronizers
    typedef enum logic [2:0] {
        IDLE, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, SIWU_PULSE, RECOVER
    } state_t;

    localparam int MAX_RW  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int MAX_CYC = (MAX_RW > REC_CYC) ? MAX_RW : REC_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            rxf_m, rxf_s, txe_m, txe_s;
    logic            flush_pend, last_rd, drive;
    logic [DATA-1:0] dout;
    logic            rd_ok, wr_ok, take_rd, take_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_m <= 1'b1;
            rxf_s <= 1'b1;
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            rxf_m <= RXF;
            rxf_s <= rxf_m;
            txe_m <= TXE;
            txe_s <= txe_m;
        end
    end

    assign rd_ok   = !rxf_s && !rx_valid;
    assign wr_ok   = !txe_s && tx_valid;
    // When both sides are eligible, the side not served last wins.
    assign take_rd = rd_ok && (!wr_ok || !last_rd);
    assign take_wr = wr_ok && !take_rd;

    assign DBUS = drive ? dout : {DATA{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            RD         <= 1'b1;
            WR         <= 1'b1;
            SIWU       <= 1'b1;
            drive      <= 1'b0;
            dout       <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            flush_pend <= 1'b0;
            last_rd    <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (flush)
                flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        state      <= SIWU_PULSE;
                        SIWU       <= 1'b0;
                        cnt        <= CW'(WR_CYC - 1);
                        busy       <= 1'b1;
                        flush_pend <= 1'b0;
                    end else if (take_rd) begin
                        state   <= RD_PULSE;
                        RD      <= 1'b0;
                        cnt     <= CW'(RD_CYC - 1);
                        busy    <= 1'b1;
                        last_rd <= 1'b1;
                    end else if (take_wr) begin
                        state    <= WR_SETUP;
                        tx_ready <= 1'b1;
                        dout     <= tx_data;
                        drive    <= 1'b1;
                        busy     <= 1'b1;
                        last_rd  <= 1'b0;
                    end
                end
                RD_PULSE: begin
                    if (cnt == '0) begin
                        RD       <= 1'b1;
                        rx_data  <= DBUS;
                        rx_valid <= 1'b1;
                        state    <= RECOVER;
                        cnt      <= CW'(REC_CYC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR_SETUP: begin
                    WR    <= 1'b0;
                    cnt   <= CW'(WR_CYC - 1);
                    state <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        WR    <= 1'b1;
                        state <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR_HOLD: begin
                    drive <= 1'b0;
                    state <= RECOVER;
                    cnt   <= CW'(REC_CYC - 1);
                end
                SIWU_PULSE: begin
                    if (cnt == '0) begin
                        SIWU  <= 1'b1;
                        state <= RECOVER;
                        cnt   <= CW'(REC_CYC - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    RD    <= 1'b1;
                    WR    <= 1'b1;
                    SIWU  <= 1'b1;
                    drive <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft2232_fifo_ctrl.sv
// Bench for ft2232_fifo_ctrl: directed scenarios plus random traffic, all checked
// each cycle against a transaction-schedule model of the controller.
module tb_ft2232_fifo_ctrl;

    localparam int RD_CYC  = 4;
    localparam int WR_CYC  = 4;
    localparam int REC_CYC = 3;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] DBUS;
    logic       RXF, TXE, rx_ready, tx_valid, flush;
    logic [7:0] tx_data, ft_byte;
    logic       RD, WR, SIWU, rx_valid, tx_ready, busy;
    logic [7:0] rx_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // FT2232 side: drives the bus while RD is low; idle bus floats high.
    assign DBUS = RD ? 8'bzzzzzzzz : ft_byte;
    pullup (DBUS);

    ft2232_fifo_ctrl #(.DATA(8), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .REC_CYC(REC_CYC)) dut (
        .clk(clk), .rst(rst), .DBUS(DBUS), .RXF(RXF), .TXE(TXE),
        .RD(RD), .WR(WR), .SIWU(SIWU),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .flush(flush), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each grant expands into a list of per-cycle expected outputs.
    typedef struct packed {
        logic       rd, wr, siwu, busy, txr, drv, cap;
        logic [7:0] dv;
    } exp_t;

    exp_t sched[$];
    exp_t cur;
    logic m_rxv, m_pend, m_last_rd, m_fl, m_rd_ok, m_wr_ok;
    logic m_rxf1, m_rxf2, m_txe1, m_txe2;
    logic [7:0] m_rxd, exp_bus;

    function automatic exp_t mk(input logic rd, input logic wr, input logic sw,
                                input logic txr, input logic drv, input logic cap,
                                input logic [7:0] dv);
        exp_t e;
        e.rd = rd; e.wr = wr; e.siwu = sw; e.busy = 1'b1;
        e.txr = txr; e.drv = drv; e.cap = cap; e.dv = dv;
        return e;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = mk(1, 1, 1, 0, 0, 0, 8'h00);
        e.busy = 1'b0;
        return e;
    endfunction

    function automatic void push_tail(input logic cap0);
        for (int i = 0; i < REC_CYC; i++)
            sched.push_back(mk(1, 1, 1, 0, 0, (i == 0) ? cap0 : 1'b0, 8'h00));
        sched.push_back(idle_e());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sched.delete();
            cur = idle_e();
            m_rxv = 0; m_rxd = 8'h00; m_pend = 0; m_last_rd = 0;
            m_rxf1 = 1; m_rxf2 = 1; m_txe1 = 1; m_txe2 = 1;
        end else begin
            m_fl    = m_pend || flush;
            m_rd_ok = !m_rxf2 && !m_rxv;
            m_wr_ok = !m_txe2 && tx_valid;
            m_pend  = m_fl;
            if (sched.size() == 0) begin
                if (m_fl) begin
                    m_pend = 0;
                    for (int i = 0; i < WR_CYC; i++) sched.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00));
                    push_tail(0);
                end else if (m_rd_ok && (!m_wr_ok || !m_last_rd)) begin
                    m_last_rd = 1;
                    for (int i = 0; i < RD_CYC; i++) sched.push_back(mk(0, 1, 1, 0, 0, 0, 8'h00));
                    push_tail(1);
                end else if (m_wr_ok) begin
                    m_last_rd = 0;
                    sched.push_back(mk(1, 1, 1, 1, 1, 0, tx_data));
                    for (int i = 0; i < WR_CYC; i++) sched.push_back(mk(1, 0, 1, 0, 1, 0, tx_data));
                    sched.push_back(mk(1, 1, 1, 0, 1, 0, tx_data));
                    push_tail(0);
                end
            end
            if (sched.size() != 0) cur = sched.pop_front();
            else cur = idle_e();
            if (cur.cap) begin
                m_rxv = 1; m_rxd = ft_byte;
            end else if (m_rxv && rx_ready) begin
                m_rxv = 0;
            end
            m_rxf2 = m_rxf1; m_rxf1 = RXF;
            m_txe2 = m_txe1; m_txe1 = TXE;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_bus = cur.drv ? cur.dv : (cur.rd ? 8'hFF : ft_byte);
            chk("RD", RD, cur.rd);
            chk("WR", WR, cur.wr);
            chk("SIWU", SIWU, cur.siwu);
            chk("busy", busy, cur.busy);
            chk("tx_ready", tx_ready, cur.txr);
            chk("rx_valid", rx_valid, m_rxv);
            chk("rx_data", rx_data, m_rxd);
            chk("DBUS", DBUS, exp_bus);
            chk("strobe_excl", 32'(!RD) + 32'(!WR) + 32'(!SIWU) <= 1, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, lo, hi, cnt_a, cnt_b, cnt_c, c, wr_end, ss;
        logic prev;
        string grants;

        rst = 1'b1; RXF = 1; TXE = 1; rx_ready = 1; tx_valid = 0; flush = 0;
        tx_data = 8'h00; ft_byte = 8'hA5;
        repeat (3) step();
        chk("reset_RD", RD, 1);
        chk("reset_busy", busy, 0);
        chk("reset_DBUS", DBUS, 8'hFF);
        rst = 1'b0;
        step();

        // read
        RXF = 0;
        n = 0;
        while (RD && n < 50) begin step(); n++; end
        chk("rd_start", RD, 0);
        lo = 0;
        while (!RD && lo < 50) begin step(); lo++; end
        chk("rd_low_cycles", lo, 4);
        chk("rd_valid", rx_valid, 1);
        chk("rd_data", rx_data, 8'hA5);
        step();
        chk("rd_valid_consumed", rx_valid, 0);
        hi = 2;
        while (RD && hi < 50) begin step(); hi++; end
        chk("rd_gap_ge3", hi >= 3, 1);
        RXF = 1;
        repeat (20) step();

        // write
        TXE = 0; tx_valid = 1; tx_data = 8'h3C;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_ready) begin cnt_a++; tx_valid = 0; end
            if (!WR) cnt_b++;
            if (DBUS == 8'h3C) cnt_c++;
        end
        chk("wr_tx_ready_pulses", cnt_a, 1);
        chk("wr_low_cycles", cnt_b, 4);
        chk("wr_dbus_cycles", cnt_c, 6);
        chk("wr_dbus_released", DBUS, 8'hFF);

        // arbitration
        TXE = 1;
        reset_dut();
        RXF = 0; TXE = 0; tx_valid = 1; tx_data = 8'h11; rx_ready = 1;
        grants = ""; prev = 1; n = 0;
        while (grants.len() < 4 && n < 300) begin
            step(); n++;
            if (!RD && prev) grants = {grants, "R"};
            if (tx_ready) begin grants = {grants, "W"}; tx_data = 8'($urandom); end
            prev = RD;
        end
        chk("arb_count", grants.len(), 4);
        chk("arb_order", (grants == "RWRW") ? 1 : 0, 1);
        tx_valid = 0; RXF = 1; TXE = 1;
        repeat (20) step();

        // backpressure
        reset_dut();
        RXF = 0; rx_ready = 0;
        cnt_a = 0; prev = 1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!RD && prev) cnt_a++;
            prev = RD;
        end
        chk("bp_single_read", cnt_a, 1);
        chk("bp_valid_held", rx_valid, 1);
        rx_ready = 1;
        n = 0;
        while (RD && n < 30) begin step(); n++; end
        chk("bp_resume_read", RD, 0);
        RXF = 1;
        repeat (20) step();

        // flush during a write
        reset_dut();
        TXE = 0; tx_data = 8'h5A; tx_valid = 1;
        n = 0;
        while (WR && n < 50) begin step(); if (tx_ready) tx_valid = 0; n++; end
        chk("fl_wr_start", WR, 0);
        flush = 1; step(); flush = 0; step(); flush = 1; step(); flush = 0;
        cnt_a = 0; cnt_b = 0; c = 0; wr_end = -1; ss = -1; prev = 1;
        for (int i = 0; i < 60; i++) begin
            step(); c++;
            if (WR && wr_end < 0) wr_end = c;
            if (!SIWU) cnt_b++;
            if (!SIWU && prev) begin cnt_a++; if (ss < 0) ss = c; end
            prev = SIWU;
        end
        chk("fl_siwu_pulses", cnt_a, 1);
        chk("fl_siwu_low", cnt_b, 4);
        chk("fl_after_write", (ss > wr_end && wr_end > 0) ? 1 : 0, 1);

        // reset in WR_PULSE cycle 2
        tx_data = 8'hC3; tx_valid = 1;
        n = 0;
        while (WR && n < 50) begin step(); n++; end
        chk("rs_wr_start", WR, 0);
        step();
        #1 rst = 1'b1;
        #1;
        chk("rs_WR_high", WR, 1);
        chk("rs_DBUS_z", DBUS, 8'hFF);
        chk("rs_busy", busy, 0);
        chk("rs_tx_ready", tx_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 2; i++) begin step(); if (tx_ready) cnt_a++; end
        chk("rs_no_ready", cnt_a, 0);
        n = 0;
        while (!tx_ready && n < 20) begin step(); n++; end
        chk("rs_new_grant", tx_ready, 1);
        tx_valid = 0;
        repeat (20) step();

        // random traffic
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(7) == 0) RXF = ~RXF;
            if ($urandom_range(7) == 0) TXE = ~TXE;
            rx_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(39) == 0);
            if (tx_ready) begin
                tx_valid = 1'($urandom_range(1));
                tx_data = 8'($urandom);
            end else if (!tx_valid && $urandom_range(4) == 0) begin
                tx_valid = 1;
                tx_data = 8'($urandom);
            end
            if (RD && $urandom_range(2) == 0) ft_byte = 8'($urandom);
        end
        flush = 0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
